// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter
// Purpose : Round-robin arbiter that lets two initiators share one BRAM port.
// Revision: 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid_a,
    input  logic                  req_write_a,
    input  logic [ADDR_WIDTH-1:0] req_addr_a,
    input  logic [DATA_WIDTH-1:0] req_wdata_a,
    output logic                  req_ready_a,
    output logic                  rsp_valid_a,
    output logic [DATA_WIDTH-1:0] rsp_rdata_a,
    input  logic                  req_valid_b,
    input  logic                  req_write_b,
    input  logic [ADDR_WIDTH-1:0] req_addr_b,
    input  logic [DATA_WIDTH-1:0] req_wdata_b,
    output logic                  req_ready_b,
    output logic                  rsp_valid_b,
    output logic [DATA_WIDTH-1:0] rsp_rdata_b,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic r_last_b;   // 1 when port B received the most recent grant
    logic r_port_b;   // port that owns the operation in flight
    logic r_write;    // operation in flight is a write

    logic w_grant_a;
    logic w_grant_b;
    logic w_open;
    logic w_accept;

    // A tie goes to whichever port was not served last.
    assign w_grant_a = req_valid_a & (~req_valid_b | r_last_b);
    assign w_grant_b = req_valid_b & (~req_valid_a | ~r_last_b);
    assign w_open    = ((r_state == S_IDLE) || (r_state == S_RESP)) & ~reset;

    assign req_ready_a = w_open & w_grant_a;
    assign req_ready_b = w_open & w_grant_b;
    assign w_accept    = req_ready_a | req_ready_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   w_next_state = w_accept ? S_ACCESS : S_IDLE;
            S_ACCESS: w_next_state = S_WAIT;
            S_WAIT:   w_next_state = S_RESP;
            S_RESP:   w_next_state = w_accept ? S_ACCESS : S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_we      <= 1'b0;
            rsp_valid_a <= 1'b0;
            rsp_valid_b <= 1'b0;
            rsp_rdata_a <= '0;
            rsp_rdata_b <= '0;
            r_last_b    <= 1'b1;
            r_port_b    <= 1'b0;
            r_write     <= 1'b0;
        end else begin
            rsp_valid_a <= 1'b0;
            rsp_valid_b <= 1'b0;

            if (w_accept) begin
                mem_addr  <= req_ready_b ? req_addr_b  : req_addr_a;
                mem_wdata <= req_ready_b ? req_wdata_b : req_wdata_a;
                mem_we    <= req_ready_b ? req_write_b : req_write_a;
                r_write   <= req_ready_b ? req_write_b : req_write_a;
                r_port_b  <= req_ready_b;
                r_last_b  <= req_ready_b;
            end

            if (r_state == S_ACCESS) begin
                mem_we <= 1'b0;
            end

            // mem_wdata still holds the write data, so it doubles as the echo.
            if (r_state == S_WAIT) begin
                if (r_port_b) begin
                    rsp_valid_b <= 1'b1;
                    rsp_rdata_b <= r_write ? mem_wdata : mem_rdata;
                end else begin
                    rsp_valid_a <= 1'b1;
                    rsp_rdata_a <= r_write ? mem_wdata : mem_rdata;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Responder side of the two-port memory request interface. Accepts read/write requests from two initiators (port A, port B) over a valid/ready handshake. Arbitrates them round-robin onto a single synchronous-read BRAM port and returns read data, or a write acknowledge, with a fixed latency. It sits between CPU-side requesters and one BRAM port, so a single-port memory can serve two masters.

Parameters:
DATA_WIDTH, 16, width of request write data, response data and BRAM data.
ADDR_WIDTH, 16, width of request address and BRAM address.

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
req_valid_a  input  1  port A request present.
req_write_a  input  1  port A: 1 = write, 0 = read.
req_addr_a  input  ADDR_WIDTH  port A address.
req_wdata_a  input  DATA_WIDTH  port A write data.
req_ready_a  output  1  port A request accepted this cycle when valid & ready.
rsp_valid_a  output  1  one-cycle pulse: port A response available.
rsp_rdata_a  output  DATA_WIDTH  port A read data, or echoed write data.
req_valid_b, req_write_b, req_addr_b, req_wdata_b, req_ready_b, rsp_valid_b, rsp_rdata_b  same as port A, for port B.
mem_addr  output  ADDR_WIDTH  BRAM address (registered).
mem_wdata  output  DATA_WIDTH  BRAM write data (registered).
mem_we  output  1  BRAM write enable (registered).
mem_rdata  input  DATA_WIDTH  BRAM read data, valid the cycle after the BRAM samples the address.

Behaviour:
- Clock and reset: one clock domain; synchronous active-high reset on clk.
- Reset values: all outputs 0. state = IDLE. last_grant = B, so A wins the first tie. While reset is high, req_ready_a and req_ready_b are forced to 0.
- States:
  - IDLE: wait for a request.
  - ACCESS: BRAM samples the mem_* outputs.
  - WAIT: mem_rdata becomes valid.
  - RESP: rsp_valid pulse.
- Ready: req_ready_x is combinational and is 1 only when state is IDLE or RESP, reset is low, and the arbiter grants x.
- Arbitration:
  - Only one valid: grant that port.
  - Both valid: grant the port that is not last_grant.
  - last_grant updates on each acceptance.
  - Ready is never high on both ports in the same cycle.
- Acceptance edge E0 (valid & ready):
  - Register mem_addr = req_addr_x, mem_wdata = req_wdata_x, mem_we = req_write_x.
  - Latch the granted port id and the write flag.
  - state -> ACCESS.
- Request signals are sampled only at E0. Initiators may change them afterwards.
- E1: BRAM samples the registered signals, so a write commits here. mem_we -> 0. state -> WAIT.
- E2:
  - Read: rsp_rdata_x = mem_rdata.
  - Write: rsp_rdata_x = latched write data.
  - rsp_valid_x = 1, for the granted port only. state -> RESP.
- E3:
  - rsp_valid_x -> 0.
  - If a request is accepted at E3: same actions as E0, state -> ACCESS.
  - Otherwise: state -> IDLE.
- Latency and throughput:
  - rsp_valid asserts 2 clocks after the accept edge and stays high exactly 1 cycle.
  - Maximum throughput is one request per 3 clocks.
- Holding values: rsp_rdata_x holds its last value until the next response to that port. mem_addr and mem_wdata hold their last values when idle.
- Starvation: with both ports continuously valid, grants alternate A, B, A, B…
- Reset mid-operation:
  - Reset high at E0: no acceptance.
  - Reset high at E1 or later: the operation is aborted and no rsp_valid is produced. A write still commits at E1, because the BRAM samples mem_we=1 before the reset takes effect.
- Address range: no range checking; the full ADDR_WIDTH space is passed through unchanged.

Test Plan:
- Reset, then A writes addr 0x0005 data 0xBEEF -> req_ready_a=1 at E0; mem_we=1 for exactly one cycle; rsp_valid_a pulses 2 clocks later with rsp_rdata_a=0xBEEF; rsp_valid_b stays 0.
- B reads addr 0x0005 after the previous write -> rsp_valid_b pulses 2 clocks after accept; rsp_rdata_b=0xBEEF; rsp_rdata_a unchanged.
- A and B both valid from reset with reads of 0x0001/0x0002 held continuously -> grant order A, B, A, B; accept edges 3 clocks apart; each response routed to the correct port.
- B write 0x1234 to 0x0010, then an A read of 0x0010 presented in B's RESP cycle -> A accepted in that RESP cycle (back-to-back); rsp_rdata_a=0x1234.
- Reset asserted for one cycle at E1 of an A write 0x00FF to 0x0003 -> no rsp_valid_a; state IDLE; a subsequent B read of 0x0003 returns 0x00FF.
- Reset asserted during E0 of an A read -> request not accepted, no memory activity; A accepted on the first cycle after reset deasserts.
